// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared definitions for the dmem arbiter slice.
//   XLEN   - data/address width
//   size_e - access size encodings carried on *_size / mem_lwhb / mem_swhb
//   port_e - requester identity (C = CPU MEM stage, D = DMA/loader)
package dmem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester ports and the dmem port.
//   c_* / d_* : request fields in, gnt/rvalid/rdata/err out (arbiter view)
//   mem_*     : dmem control out, mem_rd in (arbiter view)
// Modports: slave = arbiter, master = environment (requesters + dmem).
interface dmem_arbiter_if #(
    parameter int unsigned XLEN = dmem_arbiter_pkg::XLEN
);
    logic            c_req,    d_req;
    logic            c_we,     d_we;
    logic [XLEN-1:0] c_addr,   d_addr;
    logic [XLEN-1:0] c_wdata,  d_wdata;
    logic [1:0]      c_size,   d_size;
    logic            c_lu,     d_lu;
    logic            c_gnt,    d_gnt;
    logic            c_rvalid, d_rvalid;
    logic [XLEN-1:0] c_rdata,  d_rdata;
    logic            c_err,    d_err;
    logic            mem_we;
    logic [XLEN-1:0] mem_a;
    logic [XLEN-1:0] mem_wd;
    logic [1:0]      mem_lwhb;
    logic [1:0]      mem_swhb;
    logic            mem_lu;
    logic [XLEN-1:0] mem_rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_size, c_lu,
        input  d_req, d_we, d_addr, d_wdata, d_size, d_lu,
        output c_gnt, c_rvalid, c_rdata, c_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_we, mem_a, mem_wd, mem_lwhb, mem_swhb, mem_lu,
        input  mem_rd
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_size, c_lu,
        output d_req, d_we, d_addr, d_wdata, d_size, d_lu,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_we, mem_a, mem_wd, mem_lwhb, mem_swhb, mem_lu,
        output mem_rd
    );

endinterface

// File: rtl/dmem_req_check.sv
// dmem_req_check: combinational legality check of one dmem request.
//   i_addr - byte address
//   i_size - access size (size_e encoding)
//   o_err  - 1 = illegal size, misaligned, or beyond DMEM_BYTES
module dmem_req_check
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW         = XLEN,
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic [AW-1:0] i_addr,
    input  logic [1:0]    i_size,
    output logic          o_err
);

    always_comb begin
        o_err = 1'b0;
        if (i_size == SZ_NONE)                           o_err = 1'b1;
        if (i_size == SZ_WORD && i_addr[1:0] != 2'b00)   o_err = 1'b1;
        if (i_size == SZ_HALF && i_addr[0])              o_err = 1'b1;
        if (i_addr >= AW'(DMEM_BYTES))                   o_err = 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-issue arbiter sharing dmem between CPU (C) and DMA (D).
//   clk, reset - clock, synchronous active-high reset
//   bus        - dmem_arbiter_if.slave: both request ports and the dmem port
// Grants and dmem controls are combinational; responses are registered and
// appear exactly one cycle after the grant.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = dmem_arbiter_pkg::XLEN,
    parameter int unsigned DMEM_BYTES = 4096,
    parameter int unsigned CPU_PRIO   = 0,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    port_e           r_last;
    logic [3:0]      r_wait_cnt;
    logic            r_c_rvalid;
    logic            r_d_rvalid;
    logic            r_err;
    logic [XLEN-1:0] r_rdata;

    logic            w_c_gnt;
    logic            w_d_gnt;
    logic            w_force_d;
    logic            w_any;
    logic            w_we;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_wdata;
    logic [1:0]      w_size;
    logic            w_lu;
    logic            w_chk_err;
    logic            w_err;
    logic            w_ok;

    // Grant selection; D is decided first and C takes whatever is left.
    always_comb begin
        w_c_gnt   = 1'b0;
        w_d_gnt   = 1'b0;
        w_force_d = 1'b0;
        if (!reset) begin
            if (CPU_PRIO != 0) begin
                w_force_d = bus.d_req && (r_wait_cnt == 4'(MAX_WAIT));
                w_d_gnt   = bus.d_req && (!bus.c_req || w_force_d);
            end else begin
                w_d_gnt   = bus.d_req && (!bus.c_req || r_last == PORT_C);
            end
            w_c_gnt = bus.c_req && !w_d_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= PORT_C;
            r_wait_cnt <= '0;
        end else begin
            if (w_c_gnt)      r_last <= PORT_C;
            else if (w_d_gnt) r_last <= PORT_D;

            if (!bus.d_req || w_d_gnt)
                r_wait_cnt <= '0;
            else if (CPU_PRIO != 0 && r_wait_cnt != 4'hF)
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Request mux: fields of the granted port (C fields when idle, unused).
    assign w_any   = w_c_gnt | w_d_gnt;
    assign w_we    = w_d_gnt ? bus.d_we    : bus.c_we;
    assign w_addr  = w_d_gnt ? bus.d_addr  : bus.c_addr;
    assign w_wdata = w_d_gnt ? bus.d_wdata : bus.c_wdata;
    assign w_size  = w_d_gnt ? bus.d_size  : bus.c_size;
    assign w_lu    = w_d_gnt ? bus.d_lu    : bus.c_lu;

    dmem_req_check #(
        .AW         (XLEN),
        .DMEM_BYTES (DMEM_BYTES)
    ) u_check (
        .i_addr (w_addr),
        .i_size (w_size),
        .o_err  (w_chk_err)
    );

    assign w_err = w_any && w_chk_err;
    assign w_ok  = w_any && !w_chk_err;

    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_a    = '0;
        bus.mem_wd   = '0;
        bus.mem_lwhb = SZ_NONE;
        bus.mem_swhb = SZ_NONE;
        bus.mem_lu   = 1'b0;
        if (w_ok) begin
            bus.mem_a  = w_addr;
            bus.mem_lu = w_lu;
            if (w_we) begin
                bus.mem_we   = !reset;
                bus.mem_swhb = w_size;
                bus.mem_wd   = w_wdata;
            end else begin
                bus.mem_lwhb = w_size;
            end
        end
    end

    // Shared response register; only one port can be valid, so err/rdata
    // are qualified per port on the way out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_c_rvalid <= w_c_gnt;
            r_d_rvalid <= w_d_gnt;
            r_err      <= w_err;
            r_rdata    <= (w_ok && !w_we) ? bus.mem_rd : '0;
        end
    end

    assign bus.c_gnt    = w_c_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.c_rvalid = r_c_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.c_err    = r_c_rvalid & r_err;
    assign bus.d_err    = r_d_rvalid & r_err;
    assign bus.c_rdata  = r_c_rvalid ? r_rdata : '0;
    assign bus.d_rdata  = r_d_rvalid ? r_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
//   dut0 - round-robin instance backed by a 4 KiB byte memory model
//   dut1 - fixed-priority instance (MAX_WAIT=4), grant pattern only
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.XLEN(32)) bus0 ();
    dmem_arbiter_if #(.XLEN(32)) bus1 ();

    dmem_arbiter #(
        .XLEN(32), .DMEM_BYTES(4096), .CPU_PRIO(0), .MAX_WAIT(4)
    ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    dmem_arbiter #(
        .XLEN(32), .DMEM_BYTES(4096), .CPU_PRIO(1), .MAX_WAIT(4)
    ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Byte-addressed dmem model: combinational read, write at the rising edge.
    logic [7:0]  m [0:4095];
    logic [11:0] ra;
    logic [31:0] rword;

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input logic lu);
        case (sz)
            2'b11:   return w;
            2'b10:   return lu ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            2'b01:   return lu ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        ra          = bus0.mem_a[11:0];
        rword       = {m[ra + 12'd3], m[ra + 12'd2], m[ra + 12'd1], m[ra]};
        bus0.mem_rd = ext(rword, bus0.mem_lwhb, bus0.mem_lu);
    end

    always @(posedge clk) begin
        if (bus0.mem_we) begin
            m[bus0.mem_a[11:0]] = bus0.mem_wd[7:0];
            if (bus0.mem_swhb[1]) m[bus0.mem_a[11:0] + 12'd1] = bus0.mem_wd[15:8];
            if (bus0.mem_swhb == 2'b11) begin
                m[bus0.mem_a[11:0] + 12'd2] = bus0.mem_wd[23:16];
                m[bus0.mem_a[11:0] + 12'd3] = bus0.mem_wd[31:24];
            end
        end
    end

    assign bus1.mem_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic lu);
        bus0.c_req = req; bus0.c_we = we; bus0.c_addr = a;
        bus0.c_wdata = wd; bus0.c_size = sz; bus0.c_lu = lu;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic lu);
        bus0.d_req = req; bus0.d_we = we; bus0.d_addr = a;
        bus0.d_wdata = wd; bus0.d_size = sz; bus0.d_lu = lu;
    endtask

    initial begin
        reset = 1'b1;
        set_c(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
        set_d(1'b1, 1'b1, 32'h300, 32'h99, 2'b01, 1'b0);
        bus1.c_req = 1'b1; bus1.c_we = 1'b0; bus1.c_addr = '0;
        bus1.c_wdata = '0; bus1.c_size = 2'b11; bus1.c_lu = 1'b0;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = '0;
        bus1.d_wdata = '0; bus1.d_size = 2'b11; bus1.d_lu = 1'b0;
        tick(); tick();

        // Reset state with both ports requesting
        chk("rst_c_gnt",   {31'b0, bus0.c_gnt},    32'h0);
        chk("rst_d_gnt",   {31'b0, bus0.d_gnt},    32'h0);
        chk("rst_c_rvld",  {31'b0, bus0.c_rvalid}, 32'h0);
        chk("rst_d_rvld",  {31'b0, bus0.d_rvalid}, 32'h0);
        chk("rst_rdata",   bus0.c_rdata | bus0.d_rdata, 32'h0);
        chk("rst_mem_we",  {31'b0, bus0.mem_we},   32'h0);
        chk("rst_whb",     {28'b0, bus0.mem_lwhb, bus0.mem_swhb}, 32'h0);
        chk("rst_p_gnt",   {30'b0, bus1.c_gnt, bus1.d_gnt}, 32'h0);

        // Preload through port D
        reset = 1'b0;
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        set_d(1'b1, 1'b1, 32'h100, 32'h84332211, 2'b11, 1'b0);
        bus1.c_req = 1'b0; bus1.d_req = 1'b0;
        #1;
        chk("pre_gnt",  {31'b0, bus0.d_gnt},  32'h1);
        chk("pre_we",   {31'b0, bus0.mem_we}, 32'h1);
        chk("pre_wd",   bus0.mem_wd,          32'h84332211);
        tick();
        set_d(1'b1, 1'b1, 32'h300, 32'h5A, 2'b01, 1'b0);
        tick();
        set_d(1'b1, 1'b1, 32'h200, 32'h55667788, 2'b11, 1'b0);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);

        // Single load word
        set_c(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
        #1;
        chk("lw_gnt",   {31'b0, bus0.c_gnt},  32'h1);
        chk("lw_a",     bus0.mem_a,           32'h100);
        chk("lw_lwhb",  {30'b0, bus0.mem_lwhb}, 32'h3);
        tick();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        chk("lw_rvld",  {31'b0, bus0.c_rvalid}, 32'h1);
        chk("lw_rdata", bus0.c_rdata,         32'h84332211);
        chk("lw_err",   {31'b0, bus0.c_err},  32'h0);
        tick();
        chk("lw_clr",   {31'b0, bus0.c_rvalid}, 32'h0);

        // Byte sign vs zero extension, back to back
        set_c(1'b1, 1'b0, 32'h103, 32'h0, 2'b01, 1'b0);
        tick();
        set_c(1'b1, 1'b0, 32'h103, 32'h0, 2'b01, 1'b1);
        #1;
        chk("lbu_gnt",  {31'b0, bus0.c_gnt},  32'h1);
        chk("lb_rdata", bus0.c_rdata,         32'hFFFFFF84);
        tick();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        chk("lbu_rdata", bus0.c_rdata,        32'h00000084);

        // Round-robin tie: D, C, D, C
        set_c(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
        set_d(1'b1, 1'b0, 32'h200, 32'h0, 2'b11, 1'b0);
        #1;
        chk("rr1", {30'b0, bus0.c_gnt, bus0.d_gnt}, 32'h1);
        tick();
        chk("rr2", {30'b0, bus0.c_gnt, bus0.d_gnt}, 32'h2);
        chk("rr2_drdata", bus0.d_rdata, 32'h55667788);
        tick();
        chk("rr3", {30'b0, bus0.c_gnt, bus0.d_gnt}, 32'h1);
        chk("rr3_crdata", bus0.c_rdata, 32'h84332211);
        tick();
        chk("rr4", {30'b0, bus0.c_gnt, bus0.d_gnt}, 32'h2);
        tick();

        // Errors: granted, no memory access, err response with zero data
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        set_c(1'b1, 1'b1, 32'h101, 32'hFFFFFFFF, 2'b10, 1'b0);
        #1;
        chk("eh_gnt", {31'b0, bus0.c_gnt}, 32'h1);
        chk("eh_we",  {31'b0, bus0.mem_we}, 32'h0);
        chk("eh_swhb", {30'b0, bus0.mem_swhb}, 32'h0);
        tick();
        set_c(1'b1, 1'b1, 32'h102, 32'hFFFFFFFF, 2'b11, 1'b0);
        #1;
        chk("eh_err",   {31'b0, bus0.c_err}, 32'h1);
        chk("eh_rdata", bus0.c_rdata, 32'h0);
        chk("ew_gnt",   {31'b0, bus0.c_gnt}, 32'h1);
        chk("ew_we",    {31'b0, bus0.mem_we}, 32'h0);
        tick();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        set_d(1'b1, 1'b0, 32'h1000, 32'h0, 2'b01, 1'b0);
        #1;
        chk("ew_err",   {31'b0, bus0.c_err}, 32'h1);
        chk("eb_gnt",   {31'b0, bus0.d_gnt}, 32'h1);
        chk("eb_lwhb",  {30'b0, bus0.mem_lwhb}, 32'h0);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        set_c(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0);
        #1;
        chk("eb_err",   {31'b0, bus0.d_err}, 32'h1);
        chk("eb_rdata", bus0.d_rdata, 32'h0);
        chk("en_lwhb",  {30'b0, bus0.mem_lwhb}, 32'h0);
        tick();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        chk("en_err",   {31'b0, bus0.c_err}, 32'h1);
        chk("e_mem",    {m[12'h103], m[12'h102], m[12'h101], m[12'h100]}, 32'h84332211);

        // Store half then load half-unsigned next cycle
        set_d(1'b1, 1'b1, 32'h200, 32'h1234BEEF, 2'b10, 1'b0);
        #1;
        chk("sh_we",   {31'b0, bus0.mem_we}, 32'h1);
        chk("sh_swhb", {30'b0, bus0.mem_swhb}, 32'h2);
        chk("sh_wd",   bus0.mem_wd, 32'h1234BEEF);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        set_c(1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b1);
        #1;
        chk("sh_rvld",  {31'b0, bus0.d_rvalid}, 32'h1);
        chk("sh_rdata", bus0.d_rdata, 32'h0);
        chk("lhu_gnt",  {31'b0, bus0.c_gnt}, 32'h1);
        tick();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        chk("lhu_rdata", bus0.c_rdata, 32'h0000BEEF);
        chk("sh_upper",  {24'b0, m[12'h202]}, 32'h66);

        // Leave last = D, then reset during a store
        set_d(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
        tick();
        reset = 1'b1;
        set_d(1'b1, 1'b1, 32'h300, 32'hA5, 2'b01, 1'b0);
        #1;
        chk("rs_gnt", {31'b0, bus0.d_gnt}, 32'h0);
        chk("rs_we",  {31'b0, bus0.mem_we}, 32'h0);
        tick();
        chk("rs_mem",   {24'b0, m[12'h300]}, 32'h5A);
        chk("rs_rvld",  {30'b0, bus0.c_rvalid, bus0.d_rvalid}, 32'h0);
        chk("rs_rdata", bus0.d_rdata, 32'h0);
        chk("rs_err",   {30'b0, bus0.c_err, bus0.d_err}, 32'h0);

        // After reset: RR tie goes to D; priority instance starvation guard
        set_c(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
        set_d(1'b1, 1'b0, 32'h200, 32'h0, 2'b11, 1'b0);
        bus1.c_req = 1'b1; bus1.d_req = 1'b1;
        reset = 1'b0;
        #1;
        chk("rr_after_rst", {30'b0, bus0.c_gnt, bus0.d_gnt}, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            chk("prio_gnt", {30'b0, bus1.c_gnt, bus1.d_gnt}, (k == 5) ? 32'h1 : 32'h2);
            if (k == 5) chk("wait_full", {28'b0, dut1.r_wait_cnt}, 32'h4);
            tick();
            if (k == 5) chk("wait_clr", {28'b0, dut1.r_wait_cnt}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
